// File: rtl/tlm_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : tlm_buf_if
// Description : Bundle of telemetry source requests, buffer memory write port
//               and APB reader pop/status signals around tlm_buf_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface tlm_buf_if #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               W_EN_TLM;
  logic [AW-1:0]      W_ADDR_TLM;
  logic [DW-1:0]      WD_TLM;
  logic               rd_pop;
  logic [AW-1:0]      R_ADDR_TLM;
  logic [AW:0]        FREE_CNT;
  logic               full;
  logic               empty;
  logic               udf_err;
  logic               clr_err;

  modport slave (
    input  req, req_data, rd_pop, clr_err,
    output gnt, W_EN_TLM, W_ADDR_TLM, WD_TLM, R_ADDR_TLM, FREE_CNT,
           full, empty, udf_err
  );

  modport master (
    output req, req_data, rd_pop, clr_err,
    input  gnt, W_EN_TLM, W_ADDR_TLM, WD_TLM, R_ADDR_TLM, FREE_CNT,
           full, empty, udf_err
  );
endinterface
`default_nettype wire

// File: rtl/tlm_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tlm_buf_ctrl
// Description : Round-robin write arbiter and pointer/occupancy controller for
//               the telemetry buffer memory drained by the APB reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tlm_buf_ctrl #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 8
) (
  input  wire logic  PCLK,
  input  wire logic  rst_tx,
  tlm_buf_if.slave   bus
);

  localparam int              c_DEPTH    = 1 << AW;
  localparam int              c_LW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW:0]     c_DEPTH_V  = (AW+1)'(c_DEPTH);
  localparam logic [c_LW-1:0] c_LAST_RST = c_LW'(NREQ - 1);

  logic [NREQ-1:0] r_gnt;
  logic            r_wen;
  logic [AW-1:0]   r_waddr;
  logic [DW-1:0]   r_wdata;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_occ;
  logic [AW:0]     r_free;
  logic            r_full;
  logic            r_empty;
  logic            r_udf;
  logic [c_LW-1:0] r_last;

  logic [NREQ-1:0] w_elig;
  logic            w_hi_found;
  logic [c_LW-1:0] w_hi;
  logic            w_lo_found;
  logic [c_LW-1:0] w_lo;
  logic            w_found;
  logic [c_LW-1:0] w_win;
  logic [NREQ-1:0] w_gnt_oh;
  logic [DW-1:0]   w_wdata;
  logic            w_do_wr;
  logic            w_pop_ok;
  logic            w_pop_bad;
  logic [AW:0]     w_occ_nxt;

  // Rotating priority: first eligible index above the last winner, else the
  // first eligible index at or below it (wrap-around).
  always_comb begin
    w_elig     = bus.req & ~r_gnt;
    w_hi_found = 1'b0;
    w_hi       = '0;
    w_lo_found = 1'b0;
    w_lo       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_elig[i] && !w_hi_found && (i > int'(r_last))) begin
        w_hi_found = 1'b1;
        w_hi       = c_LW'(i);
      end
      if (w_elig[i] && !w_lo_found && (i <= int'(r_last))) begin
        w_lo_found = 1'b1;
        w_lo       = c_LW'(i);
      end
    end
    w_found = w_hi_found | w_lo_found;
    w_win   = w_hi_found ? w_hi : w_lo;
  end

  always_comb begin
    w_gnt_oh = '0;
    w_wdata  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (c_LW'(i) == w_win) begin
        w_gnt_oh[i] = 1'b1;
        w_wdata     = bus.req_data[i*DW +: DW];
      end
    end
  end

  // Space is judged on pre-edge occupancy; a same-cycle pop does not help.
  always_comb begin
    w_do_wr   = w_found && (r_occ < c_DEPTH_V);
    w_pop_ok  = bus.rd_pop && (r_occ != '0);
    w_pop_bad = bus.rd_pop && (r_occ == '0);
    w_occ_nxt = r_occ;
    if (w_do_wr && !w_pop_ok) begin
      w_occ_nxt = r_occ + 1'b1;
    end else if (!w_do_wr && w_pop_ok) begin
      w_occ_nxt = r_occ - 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge rst_tx) begin
    if (!rst_tx) begin
      r_gnt   <= '0;
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_occ   <= '0;
      r_free  <= c_DEPTH_V;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_udf   <= 1'b0;
      r_last  <= c_LAST_RST;
    end else begin
      r_wen <= w_do_wr;
      r_gnt <= '0;
      if (w_do_wr) begin
        r_gnt   <= w_gnt_oh;
        r_waddr <= r_wptr;
        r_wdata <= w_wdata;
        r_wptr  <= r_wptr + 1'b1;
        r_last  <= w_win;
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_occ   <= w_occ_nxt;
      r_free  <= c_DEPTH_V - w_occ_nxt;
      r_full  <= (w_occ_nxt == c_DEPTH_V);
      r_empty <= (w_occ_nxt == '0);
      // Underflow set takes precedence over a coincident clear.
      if (w_pop_bad) begin
        r_udf <= 1'b1;
      end else if (bus.clr_err) begin
        r_udf <= 1'b0;
      end
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.W_EN_TLM   = r_wen;
  assign bus.W_ADDR_TLM = r_waddr;
  assign bus.WD_TLM     = r_wdata;
  assign bus.R_ADDR_TLM = r_rptr;
  assign bus.FREE_CNT   = r_free;
  assign bus.full       = r_full;
  assign bus.empty      = r_empty;
  assign bus.udf_err    = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_tlm_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlm_buf_ctrl
// Description : Scoreboard bench for tlm_buf_ctrl arbitration and pointers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlm_buf_ctrl;
  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 8;

  typedef logic [NREQ+AW+DW-1:0] rec_t;

  logic PCLK   = 1'b0;
  logic rst_tx = 1'b0;
  always #5 PCLK = ~PCLK;

  tlm_buf_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  tlm_buf_ctrl #(.NREQ(NREQ), .AW(AW), .DW(DW)) u_dut (
    .PCLK   (PCLK),
    .rst_tx (rst_tx),
    .bus    (bus.slave)
  );

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Advance one edge and capture any memory write the DUT issued.
  task automatic tick();
    @(posedge PCLK);
    #1;
    if (bus.W_EN_TLM) obs_q.push_back({bus.gnt, bus.W_ADDR_TLM, bus.WD_TLM});
  endtask

  function automatic rec_t mk(int src, int addr, logic [DW-1:0] d);
    return {NREQ'(1 << src), AW'(addr), d};
  endfunction

  task automatic do_reset();
    rst_tx       = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.rd_pop   = 1'b0;
    bus.clr_err  = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    rst_tx = 1'b1;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_checks++; if (bus.FREE_CNT !== 6'd32) begin n_errors++; $display("FAIL reset_free: got %0d expected 32", bus.FREE_CNT); end
    n_checks++; if (bus.empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
    n_checks++; if (bus.full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %b expected 0", bus.full); end
    n_checks++; if (bus.R_ADDR_TLM !== 5'd0) begin n_errors++; $display("FAIL reset_raddr: got %0d expected 0", bus.R_ADDR_TLM); end
    n_checks++; if (bus.gnt !== 4'b0000) begin n_errors++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
    n_checks++; if (bus.udf_err !== 1'b0) begin n_errors++; $display("FAIL reset_udf: got %b expected 0", bus.udf_err); end
    n_checks++; if (bus.W_EN_TLM !== 1'b0) begin n_errors++; $display("FAIL reset_wen: got %b expected 0", bus.W_EN_TLM); end
  endtask

  task automatic test_single_source();
    rec_t e, o;
    do_reset();
    bus.req_data = {8'h00, 8'h00, 8'h00, 8'h5A};
    bus.req      = 4'b0001;
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(0, k, 8'h5A));
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if (bus.gnt !== ((k % 2 == 1) ? 4'b0001 : 4'b0000)) begin
        n_errors++; $display("FAIL single_gnt_cycle%0d: got %b expected %b", k, bus.gnt, (k % 2 == 1) ? 4'b0001 : 4'b0000);
      end
    end
    bus.req = 4'b0000;
    tick();
    n_checks++; if (bus.FREE_CNT !== 6'd29) begin n_errors++; $display("FAIL single_free: got %0d expected 29", bus.FREE_CNT); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL single_count: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_errors++; $display("FAIL single_write: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_round_robin_fill();
    rec_t e, o;
    do_reset();
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req      = 4'b1111;
    for (int k = 0; k < 32; k++) exp_q.push_back(mk(k % 4, k, 8'h10 + 8'(k % 4)));
    for (int k = 1; k <= 34; k++) begin
      tick();
      n_checks++;
      if (bus.W_EN_TLM !== (k <= 32)) begin
        n_errors++; $display("FAIL rr_wen_cycle%0d: got %b expected %b", k, bus.W_EN_TLM, (k <= 32));
      end
    end
    n_checks++; if (bus.full !== 1'b1) begin n_errors++; $display("FAIL rr_full: got %b expected 1", bus.full); end
    n_checks++; if (bus.FREE_CNT !== 6'd0) begin n_errors++; $display("FAIL rr_free: got %0d expected 0", bus.FREE_CNT); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL rr_count: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_errors++; $display("FAIL rr_write: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // Continues from the full buffer left by the fill test.
  task automatic test_full_pop_grant();
    rec_t e, o;
    bus.req = 4'b0100;
    exp_q.push_back(mk(2, 0, 8'h12));
    tick();
    n_checks++; if (bus.gnt !== 4'b0000) begin n_errors++; $display("FAIL full_nogrant: got %b expected 0000", bus.gnt); end
    bus.rd_pop = 1'b1;
    tick();
    bus.rd_pop = 1'b0;
    n_checks++; if (bus.R_ADDR_TLM !== 5'd1) begin n_errors++; $display("FAIL full_pop_raddr: got %0d expected 1", bus.R_ADDR_TLM); end
    n_checks++; if (bus.FREE_CNT !== 6'd1) begin n_errors++; $display("FAIL full_pop_free: got %0d expected 1", bus.FREE_CNT); end
    n_checks++; if (bus.gnt !== 4'b0000) begin n_errors++; $display("FAIL full_pop_gnt: got %b expected 0000", bus.gnt); end
    tick();
    bus.req = 4'b0000;
    n_checks++; if (bus.gnt !== 4'b0100) begin n_errors++; $display("FAIL full_refill_gnt: got %b expected 0100", bus.gnt); end
    n_checks++; if (bus.FREE_CNT !== 6'd0) begin n_errors++; $display("FAIL full_refill_free: got %0d expected 0", bus.FREE_CNT); end
    n_checks++; if (bus.full !== 1'b1) begin n_errors++; $display("FAIL full_refill_full: got %b expected 1", bus.full); end
    tick();
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL full_count: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_errors++; $display("FAIL full_write: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    do_reset();
    bus.req_data = {8'h00, 8'h00, 8'hB1, 8'hA0};
    bus.req      = 4'b0011;
    for (int k = 0; k < 50; k++) exp_q.push_back(mk(k % 2, k, (k % 2 == 1) ? 8'hB1 : 8'hA0));
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (k == 10) bus.rd_pop = 1'b1;
      if (k >= 10) begin
        n_checks++;
        if (bus.FREE_CNT !== 6'd22) begin n_errors++; $display("FAIL b2b_free_cycle%0d: got %0d expected 22", k, bus.FREE_CNT); end
      end
    end
    bus.req    = 4'b0000;
    bus.rd_pop = 1'b0;
    tick();
    n_checks++; if (bus.R_ADDR_TLM !== 5'd8) begin n_errors++; $display("FAIL b2b_raddr: got %0d expected 8", bus.R_ADDR_TLM); end
    n_checks++; if (bus.FREE_CNT !== 6'd22) begin n_errors++; $display("FAIL b2b_free_end: got %0d expected 22", bus.FREE_CNT); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL b2b_count: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_errors++; $display("FAIL b2b_write: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_underflow_and_reset();
    rec_t e, o;
    do_reset();
    bus.rd_pop = 1'b1;
    tick();
    bus.rd_pop = 1'b0;
    n_checks++; if (bus.R_ADDR_TLM !== 5'd0) begin n_errors++; $display("FAIL udf_raddr: got %0d expected 0", bus.R_ADDR_TLM); end
    n_checks++; if (bus.udf_err !== 1'b1) begin n_errors++; $display("FAIL udf_set: got %b expected 1", bus.udf_err); end
    n_checks++; if (bus.FREE_CNT !== 6'd32) begin n_errors++; $display("FAIL udf_free: got %0d expected 32", bus.FREE_CNT); end
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    n_checks++; if (bus.udf_err !== 1'b0) begin n_errors++; $display("FAIL udf_clear: got %b expected 0", bus.udf_err); end
    bus.rd_pop  = 1'b1;
    bus.clr_err = 1'b1;
    tick();
    bus.rd_pop  = 1'b0;
    bus.clr_err = 1'b0;
    n_checks++; if (bus.udf_err !== 1'b1) begin n_errors++; $display("FAIL udf_set_wins: got %b expected 1", bus.udf_err); end
    bus.req_data = {8'h00, 8'h00, 8'h00, 8'h77};
    bus.req      = 4'b0001;
    exp_q.push_back(mk(0, 0, 8'h77));
    tick();
    n_checks++; if (bus.gnt !== 4'b0001) begin n_errors++; $display("FAIL rst_pre_gnt: got %b expected 0001", bus.gnt); end
    rst_tx = 1'b0;
    #1;
    n_checks++; if (bus.gnt !== 4'b0000) begin n_errors++; $display("FAIL rst_async_gnt: got %b expected 0000", bus.gnt); end
    n_checks++; if (bus.W_EN_TLM !== 1'b0) begin n_errors++; $display("FAIL rst_async_wen: got %b expected 0", bus.W_EN_TLM); end
    n_checks++; if (bus.FREE_CNT !== 6'd32) begin n_errors++; $display("FAIL rst_async_free: got %0d expected 32", bus.FREE_CNT); end
    n_checks++; if (bus.udf_err !== 1'b0) begin n_errors++; $display("FAIL rst_async_udf: got %b expected 0", bus.udf_err); end
    bus.req = 4'b0000;
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL rst_count: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_errors++; $display("FAIL rst_write: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_round_robin_fill();
    test_full_pop_grant();
    test_back_to_back();
    test_underflow_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
